// File: rtl/fpu_div_nr_seq_if.sv
// fpu_div_nr_seq_if: operand/result valid-ready bus for the sequential binary32 divider
interface fpu_div_nr_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [4:0]  out_flags;
    modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_q, out_flags);
    modport slave  (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_q, out_flags);
endinterface

// File: rtl/fpu_div_nr_seq.sv
// fpu_div_nr_seq: sequential binary32 A/B via Newton-Raphson reciprocal; one shared multiplier and adder.
// Define FPU_DIV_EXC_EN for full IEEE special-operand handling and exception flags.
module fpu_div_nr_seq #(
    parameter int NR_ITERS = 3
) (
    input logic clk,
    input logic rst_n,
    fpu_div_nr_seq_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_SPECIAL, S_SEED_MUL, S_SEED_ADD, S_IT_MUL, S_IT_SUB, S_IT_MUL2, S_FIN_MUL, S_DONE
    } state_t;

    localparam logic [31:0] C_K1   = 32'h3FF0F0F1;
    localparam logic [31:0] C_K2   = 32'h4034B4B5;
    localparam logic [31:0] C_TWO  = 32'h40000000;
    localparam logic [2:0]  C_LAST = 3'(NR_ITERS - 1);
    localparam logic [2:0]  C_SAT  = 3'(NR_ITERS);

    generate
        if (NR_ITERS < 1 || NR_ITERS > 4) begin : g_bad_iters
            $error("fpu_div_nr_seq: NR_ITERS must be in 1..4");
        end
    endgenerate

    // Normal-operand multiply, round to nearest even; operands here never leave the normal range.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [9:0]  e;
        logic [22:0] m;
        logic        g;
        logic        st;
        prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e    = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, prod[47]};
        m    = prod[47] ? prod[46:24] : prod[45:23];
        g    = prod[47] ? prod[23] : prod[22];
        st   = prod[47] ? |prod[22:0] : |prod[21:0];
        return {a[31] ^ b[31], e[7:0], m} + {31'b0, g & (st | m[0])};
    endfunction

    // Normal-operand add/subtract, round to nearest even; the mantissa carry ripples into the exponent.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  d;
        logic [49:0] ys;
        logic [27:0] r;
        logic [27:0] n;
        logic [4:0]  p;
        logic [9:0]  e;
        logic [22:0] m;
        logic        g;
        logic        st;
        {x, y} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
        d  = x[30:23] - y[30:23];
        ys = {2'b01, y[22:0], 25'b0} >> ((d > 8'd48) ? 8'd48 : d);
        r  = (x[31] ^ y[31]) ? {2'b01, x[22:0], 3'b0} - {ys[49:23], |ys[22:0]}
                             : {2'b01, x[22:0], 3'b0} + {ys[49:23], |ys[22:0]};
        p  = 5'd0;
        for (int i = 0; i < 28; i++) if (r[i]) p = 5'(i);
        n  = r << (5'd27 - p);
        e  = {2'b0, x[30:23]} + {5'b0, p} - 10'd26;
        m  = n[26:4];
        g  = n[3];
        st = |n[2:0];
        return (r == 28'b0) ? 32'b0 : {x[31], e[7:0], m} + {31'b0, g & (st | m[0])};
    endfunction

    state_t      r_state, w_next;
    logic        r_sign;
    logic [7:0]  r_ea, r_eb;
    logic [31:0] r_ma, r_mb, r_x, r_t, r_q;
    logic [4:0]  r_flags;
    logic [2:0]  r_it;

    logic [31:0] w_mul_a, w_mul_b, w_mul, w_add_a, w_add_b, w_add;
    logic signed [9:0] w_qe;
    logic [31:0] w_fin_q, w_spec_q;
    logic [4:0]  w_fin_f, w_spec_f;
    logic        w_in_spec;

    assign w_mul_a = (r_state == S_IT_MUL2) ? r_x : (r_state == S_FIN_MUL) ? r_ma : r_mb;
    assign w_mul_b = (r_state == S_SEED_MUL) ? C_K1 : (r_state == S_IT_MUL2) ? r_t : r_x;
    assign w_add_a = (r_state == S_SEED_ADD) ? C_K2 : C_TWO;
    assign w_add_b = (r_state == S_SEED_ADD) ? {1'b1, r_t[30:0]} : {~r_t[31], r_t[30:0]};
    assign w_mul   = fmul(w_mul_a, w_mul_b);
    assign w_add   = fadd(w_add_a, w_add_b);

    // p = mA*x lies in (1,4); its exponent carries the extra factor of two relative to the quotient.
    assign w_qe    = $signed({2'b0, w_mul[30:23]} + {2'b0, r_ea} - {2'b0, r_eb} - 10'd1);
    assign w_fin_q = (w_qe < 10'sd1)   ? {r_sign, 31'b0} :
                     (w_qe > 10'sd254) ? {r_sign, 8'hFF, 23'b0} : {r_sign, w_qe[7:0], w_mul[22:0]};

`ifdef FPU_DIV_EXC_EN
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_nv;
    // Subnormals share exponent 0 with zero, so they are flushed by this classification.
    assign w_in_spec = (bus.in_a[30:23] == 8'h00) | (bus.in_a[30:23] == 8'hFF) |
                       (bus.in_b[30:23] == 8'h00) | (bus.in_b[30:23] == 8'hFF);
    assign w_a_zero  = r_ea == 8'h00;
    assign w_b_zero  = r_eb == 8'h00;
    assign w_a_inf   = (r_ea == 8'hFF) & ~|r_ma[22:0];
    assign w_b_inf   = (r_eb == 8'hFF) & ~|r_mb[22:0];
    assign w_a_nan   = (r_ea == 8'hFF) & |r_ma[22:0];
    assign w_b_nan   = (r_eb == 8'hFF) & |r_mb[22:0];
    assign w_nv      = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_spec_q  = w_nv ? 32'h7FC00000 : (w_a_inf | w_b_zero) ? {r_sign, 8'hFF, 23'b0} : {r_sign, 31'b0};
    assign w_spec_f  = w_nv ? 5'b10000 : (w_b_zero & ~w_a_inf) ? 5'b01000 : 5'b00000;
    assign w_fin_f   = (w_qe < 10'sd1) ? 5'b00011 : (w_qe > 10'sd254) ? 5'b00101 : 5'b00000;
`else
    assign w_in_spec = (bus.in_a[30:23] == 8'h00) | (bus.in_b[30:23] == 8'h00);
    assign w_spec_q  = 32'h00000000;
    assign w_spec_f  = 5'b00000;
    assign w_fin_f   = 5'b00000;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: fixed one-cycle steps, loop over iterations until the counter reaches the last one
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = bus.in_valid ? (w_in_spec ? S_SPECIAL : S_SEED_MUL) : S_IDLE;
            S_SPECIAL:  w_next = S_DONE;
            S_SEED_MUL: w_next = S_SEED_ADD;
            S_SEED_ADD: w_next = S_IT_MUL;
            S_IT_MUL:   w_next = S_IT_SUB;
            S_IT_SUB:   w_next = S_IT_MUL2;
            S_IT_MUL2:  w_next = (r_it == C_LAST) ? S_FIN_MUL : S_IT_MUL;
            S_FIN_MUL:  w_next = S_DONE;
            S_DONE:     w_next = bus.out_ready ? S_IDLE : S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs: handshakes decoded from state, result held in registers
    always_comb begin
        bus.in_ready  = r_state == S_IDLE;
        bus.out_valid = r_state == S_DONE;
        bus.out_q     = r_q;
        bus.out_flags = r_flags;
    end

    // Datapath: operand capture, shared-unit writeback per state, result packing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_ea    <= 8'h00;
            r_eb    <= 8'h00;
            r_ma    <= 32'h0;
            r_mb    <= 32'h0;
            r_x     <= 32'h0;
            r_t     <= 32'h0;
            r_it    <= 3'd0;
            r_q     <= 32'h0;
            r_flags <= 5'h0;
        end else begin
            if (r_state == S_IDLE && bus.in_valid) begin
                r_sign <= bus.in_a[31] ^ bus.in_b[31];
                r_ea   <= bus.in_a[30:23];
                r_eb   <= bus.in_b[30:23];
                r_ma   <= {1'b0, 8'd127, bus.in_a[22:0]};
                r_mb   <= {1'b0, 8'd126, bus.in_b[22:0]};
                r_it   <= 3'd0;
            end
            if (r_state == S_SEED_MUL || r_state == S_IT_MUL) r_t <= w_mul;
            if (r_state == S_IT_SUB) r_t <= w_add;
            if (r_state == S_SEED_ADD) r_x <= w_add;
            if (r_state == S_IT_MUL2) begin
                r_x  <= w_mul;
                r_it <= (r_it == C_SAT) ? r_it : r_it + 3'd1;
            end
            if (r_state == S_FIN_MUL) {r_q, r_flags} <= {w_fin_q, w_fin_f};
            if (r_state == S_SPECIAL) {r_q, r_flags} <= {w_spec_q, w_spec_f};
        end
    end
endmodule
